// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate sequencer for the datapath.
// Latches one operand and applies one power-of-two stage per clock
// (1, 2, 4, ... 2**(CNT_W-1)), each stage gated by the matching count bit.
// All stages share a single stage datapath.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   start  - launch request, accepted in IDLE or DONE
//   op     - 00 ROL, 01 SLL, 10 ROR, 11 SRA
//   in     - operand
//   cnt    - shift amount, 0..WIDTH-1
//   busy   - high while stages are applied
//   done   - one-cycle pulse, out valid
//   out    - result, held until next accepted start or reset
//
// Optional build macro SHIFT_SEQ_EARLY_DONE_EN: finish SHIFT as soon as no
// higher count bits remain set. Results are unchanged, only timing differs.
module shift_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int unsigned SHW   = CNT_W + 1;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   shamt_c;
    logic [SHW-1:0]     rshamt_c;
    logic [WIDTH-1:0]   stage_res_c;
    logic               last_c;

    // Shared stage datapath: shift acc by 2**stage per the latched op.
    always_comb begin
        shamt_c  = CNT_W'(1) << stage_q;
        rshamt_c = SHW'(WIDTH) - {1'b0, shamt_c};
        case (op_q)
            OP_ROL:  stage_res_c = (acc_q << shamt_c) | (acc_q >> rshamt_c);
            OP_SLL:  stage_res_c = acc_q << shamt_c;
            OP_ROR:  stage_res_c = (acc_q >> shamt_c) | (acc_q << rshamt_c);
            OP_SRA:  stage_res_c = WIDTH'($signed(acc_q) >>> shamt_c);
            default: stage_res_c = acc_q;
        endcase
    end

`ifdef SHIFT_SEQ_EARLY_DONE_EN
    // Current stage is the last one that matters when no higher count bit is set.
    always_comb begin
        last_c = 1'b1;
        for (int i = 0; i < int'(CNT_W); i++) begin
            if ((i > int'(stage_q)) && cnt_q[i]) begin
                last_c = 1'b0;
            end
        end
    end
`else
    always_comb begin
        last_c = (stage_q == STG_W'(CNT_W - 1));
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d   = in;
                    op_d    = op;
                    cnt_d   = cnt;
                    stage_d = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q[stage_q]) begin
                    acc_d = stage_res_c;
                end
                stage_d = stage_q + STG_W'(1);
                if (last_c) begin
                    out_d   = acc_d;
                    stage_d = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: vector table plus scoreboard, with
// hand-written sequences for back-to-back, ignored start and mid-op reset.
module tb_shift_seq;

    localparam int W     = 16;
    localparam int CNT_W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op_i;
    logic [W-1:0] in_i;
    logic [3:0]   cnt_i;
    logic         busy;
    logic         done;
    logic [W-1:0] out;

    shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .in    (in_i),
        .cnt   (cnt_i),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] din;
        logic [3:0]   cnt;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        int           lat;
        int           launch;
    } sb_t;

    sb_t  sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   busy_run;
    int   done_cnt;
    logic [W-1:0] out_prev;

    // Independent bit-level reference for one full shift.
    function automatic logic [W-1:0] ref_shift(logic [1:0] o, logic [W-1:0] d, int c);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case (o)
                2'b00:   r[i] = d[(i + W - c) % W];
                2'b01:   r[i] = (i >= c) ? d[i - c] : 1'b0;
                2'b10:   r[i] = d[(i + c) % W];
                default: r[i] = (i + c < W) ? d[i + c] : d[W-1];
            endcase
        end
        return r;
    endfunction

    // Cycles from start to done.
    function automatic int exp_lat(logic [3:0] c);
        int h;
        int lat;
        h = -1;
        for (int i = 0; i < CNT_W; i++) begin
            if (c[i]) h = i;
        end
`ifdef SHIFT_SEQ_EARLY_DONE_EN
        lat = (h < 0) ? 2 : h + 2;
`else
        lat = (h + 2 > CNT_W + 1) ? h + 2 : CNT_W + 1;
`endif
        return lat;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                busy_run++;
                check("out_stable_busy", int'(out), int'(out_prev));
            end
            if (busy && done) check("busy_done_overlap", 1, 0);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("result", int'(out), int'(e.exp));
                    check("latency", cyc - e.launch, e.lat);
                    check("busy_cycles", busy_run, e.lat - 1);
                end
                busy_run = 0;
            end
        end
        out_prev = out;
    end

    // Called at a negedge: drive one start cycle, then scramble inputs.
    task automatic issue(logic [1:0] o, logic [W-1:0] d, logic [3:0] c, logic [W-1:0] e);
        sb_t s;
        start = 1'b1;
        op_i  = o;
        in_i  = d;
        cnt_i = c;
        s.exp = e;
        s.lat = exp_lat(c);
        s.launch = cyc;
        sb.push_back(s);
        @(negedge clk);
        start = 1'b0;
        op_i  = 2'($urandom_range(0, 3));
        in_i  = 16'($urandom);
        cnt_i = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[15];

    initial begin
        checks = 0; errors = 0; cyc = 0; busy_run = 0; done_cnt = 0;
        out_prev = '0;
        rst = 1'b1; start = 1'b0; op_i = '0; in_i = '0; cnt_i = '0;

        vecs[0]  = '{2'b01, 16'h00FF, 4'd4,  16'h0FF0};
        vecs[1]  = '{2'b11, 16'h8010, 4'd4,  16'hF801};
        vecs[2]  = '{2'b11, 16'h7FFF, 4'd15, 16'h0000};
        vecs[3]  = '{2'b00, 16'h8001, 4'd1,  16'h0003};
        vecs[4]  = '{2'b10, 16'h8001, 4'd15, 16'h0003};
        vecs[5]  = '{2'b00, 16'h1234, 4'd8,  16'h3412};
        vecs[6]  = '{2'b00, 16'hA5A5, 4'd0,  16'hA5A5};
        vecs[7]  = '{2'b01, 16'hA5A5, 4'd0,  16'hA5A5};
        vecs[8]  = '{2'b10, 16'hA5A5, 4'd0,  16'hA5A5};
        vecs[9]  = '{2'b11, 16'hA5A5, 4'd0,  16'hA5A5};
        vecs[10] = '{2'b01, 16'h0001, 4'd15, 16'h8000};
        vecs[11] = '{2'b11, 16'h8000, 4'd15, 16'hFFFF};
        vecs[12] = '{2'b10, 16'h1234, 4'd4,  16'h4123};
        vecs[13] = '{2'b01, 16'h00FF, 4'd2,  16'h03FC};
        vecs[14] = '{2'b11, 16'h00F0, 4'd2,  16'h003C};

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_out",  int'(out),  0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].din, vecs[i].cnt, vecs[i].exp);
            drain();
        end

        // Random operations against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [1:0]   o;
            logic [W-1:0] d;
            logic [3:0]   c;
            o = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            c = 4'($urandom_range(0, 15));
            issue(o, d, c, ref_shift(o, d, int'(c)));
            drain();
        end

        // Back-to-back: new start presented in the DONE cycle.
        issue(2'b00, 16'h8001, 4'd1, 16'h0003);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("b2b_first_done_seen", int'(done), 1);
        #1;
        issue(2'b00, 16'h1234, 4'd8, 16'h3412);
        drain();

        // Start during busy with different operands is ignored.
        begin
            int dc;
            issue(2'b01, 16'h00FF, 4'd4, 16'h0FF0);
            start = 1'b1; op_i = 2'b11; in_i = 16'hFFFF; cnt_i = 4'd15;
            @(negedge clk);
            start = 1'b0;
            drain();
            dc = done_cnt;
            repeat (10) @(negedge clk);
            check("ignored_start_no_extra_done", done_cnt - dc, 0);
            check("ignored_start_out_held", int'(out), 16'h0FF0);
        end

        // Reset on the second SHIFT edge drops the operation.
        begin
            int dc;
            issue(2'b01, 16'h00FF, 4'd3, 16'h07F8);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("midrst_busy", int'(busy), 0);
            check("midrst_done", int'(done), 0);
            check("midrst_out",  int'(out),  0);
            rst = 1'b0;
            sb.delete();
            busy_run = 0;
            dc = done_cnt;
            repeat (10) @(negedge clk);
            check("midrst_no_done", done_cnt - dc, 0);
            check("midrst_out_held", int'(out), 0);
        end

        // Fresh op after reset still works.
        issue(2'b10, 16'h0001, 4'd1, 16'h8000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift/rotate sequencer for the 16-bit datapath.
- Holds one operand and applies one power-of-two shift stage per clock (by 1, 2, 4, then 8), each stage gated by the matching count bit.
- The four stages share one stage datapath instead of a full four-level barrel shifter.
- Sits beside the ALU; the execute-stage controller launches it with start/op/cnt and waits for done.

Parameters:
WIDTH, 16, operand/result width; must equal 2**CNT_W.
CNT_W, 4, shift-count width; also the number of stages.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRA.
in  input  WIDTH  operand.
cnt  input  CNT_W  shift amount, 0..WIDTH-1.
busy  output  1  high while stages are being applied (SHIFT).
done  output  1  one-cycle pulse; out is valid.
out  output  WIDTH  result; held until the next accepted start or reset.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, out=0, and internal acc/stage/op/cnt registers cleared. Reset applies in every state, including mid-SHIFT; the operation in flight is dropped with no done.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge, latch in→acc, op→op_r, cnt→cnt_r, stage=0, go to SHIFT. Otherwise stay.
- SHIFT, busy=1, each edge:
  - If cnt_r[stage]=1, acc is shifted by 2**stage per op_r; otherwise acc is held.
  - stage increments.
  - On the edge that applies stage CNT_W-1: out←final acc, go to DONE.
- DONE: done=1 for exactly this cycle, busy=0.
  - With start=1 at this edge: accept the new operation exactly as from IDLE (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E0+CNT_W. Fixed at 5 cycles start-to-done for default parameters.
- start while busy=1 is ignored; no queuing, and inputs are not re-sampled.
- in/op/cnt need only be valid on the accepting edge; later changes have no effect.
- Shift semantics per stage, by k bits:
  - SLL fills zeros at the LSB end.
  - SRA replicates acc[WIDTH-1] into the MSB end.
  - ROL/ROR rotate with no bit loss.
- cnt=0: all stages hold; out=in after the full latency.
- Rotations are modulo WIDTH. cnt cannot exceed WIDTH-1 by width, so there is no overflow case.
- out changes only on the SHIFT→DONE edge and at reset; it is stable during IDLE and SHIFT.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_DONE_EN.
- When defined, SHIFT terminates on the first edge where all remaining count bits (cnt_r[CNT_W-1:stage+1]) are zero. That edge writes out and moves to DONE.
- Resulting latency: highest set bit index h, with done in the cycle after edge E0+h+1. cnt=0 finishes after one SHIFT edge (done after E0+1).
- When undefined, latency is fixed at CNT_W SHIFT edges as above.
- Results are identical in both builds; only the timing of done and busy differs.

Test Plan:
- Reset mid-operation: start SLL in=0x00FF cnt=3, assert rst on the 2nd SHIFT edge → busy=0, done=0, out=0; no done pulse follows.
- SLL in=0x00FF cnt=4 → done 5 cycles after start, out=0x0FF0; busy high for exactly 4 cycles.
- SRA in=0x8010 cnt=4 → out=0xF801. Then SRA in=0x7FFF cnt=15 → out=0x0000.
- ROL in=0x8001 cnt=1 → out=0x0003. Then ROR in=0x8001 cnt=15 → out=0x0003 (rotation consistency).
- Back-to-back: start held high in the DONE cycle with ROL in=0x1234 cnt=8 → second done exactly 5 cycles later, out=0x3412. A start pulse during busy with different operands is ignored, and the result is unchanged.
- cnt=0, in=0xA5A5, each op → out=0xA5A5. With SHIFT_SEQ_EARLY_DONE_EN defined, done comes 2 cycles after start; with cnt=2 it comes 3 cycles after start.
